// File: rtl/mul_pkg.sv
// Shared definitions for the integer multiply-accumulate unit and its divider sibling.
package mul_pkg;

  localparam int W     = 32;
  localparam int W2    = 2 * W;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Operand state captured at accept and held for the whole operation.
  typedef struct packed {
    logic [W:0]    mcand_mag;
    logic          neg;
    logic [W2-1:0] addend_ext;
  } op_t;

  // Magnitude of a W-bit operand as W+1 bits, so -2^(W-1) survives intact.
  function automatic logic [W:0] mag_ext(input logic [W-1:0] v, input logic sgn);
    logic [W:0] x;
    x = {sgn & v[W-1], v};
    return x[W] ? -x : x;
  endfunction

endpackage

// File: rtl/mul_int_if.sv
// Request/response bundle between the ALU sequencer and the multiplier.
interface mul_int_if;
  import mul_pkg::*;

  logic          start;
  logic          sign;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic [W-1:0]  addend;
  logic          busy;
  logic          done;
  logic [W2-1:0] prod;

  modport master (output start, sign, mcand, mplier, addend,
                  input  busy, done, prod);
  modport slave  (input  start, sign, mcand, mplier, addend,
                  output busy, done, prod);
endinterface

// File: rtl/mul_int_cond_neg.sv
// Conditional two's-complement negation of an N-bit word.
module cond_neg #(
  parameter int N = 64
) (
  input  logic         i_neg,
  input  logic [N-1:0] i_a,
  output logic [N-1:0] o_y
);
  assign o_y = i_neg ? -i_a : i_a;
endmodule

// File: rtl/mul_int.sv
// Sequential 32x32 multiply-accumulate: prod = mcand * mplier + addend.
// Radix-2 shift-add on magnitudes, then sign fix-up and addend add in one step.
module mul_int
  import mul_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  mul_int_if.slave bus
);

  state_t           r_state;
  op_t              r_op;
  logic [W-1:0]     r_acc_hi;
  logic [W-1:0]     r_mpl;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [W2-1:0]    r_prod;

  logic [W:0]       w_mcand_mag;
  logic [W-1:0]     w_mpl_mag;
  logic [W:0]       w_step;
  logic [W2-1:0]    w_acc_signed;
  logic [W2-1:0]    w_res;

  // Magnitudes of the incoming operands; mplier magnitude always fits W bits.
  assign w_mcand_mag = mag_ext(bus.mcand, bus.sign);
  assign w_mpl_mag   = (bus.sign & bus.mplier[W-1]) ? -bus.mplier : bus.mplier;

  // One shift-add step: add the multiplicand into the high half when the
  // current multiplier bit is set, keeping the carry for the right shift.
  assign w_step = r_mpl[0] ? ({1'b0, r_acc_hi} + r_op.mcand_mag)
                           : {1'b0, r_acc_hi};

  cond_neg #(.N(W2)) u_neg (
    .i_neg (r_op.neg),
    .i_a   ({r_acc_hi, r_mpl}),
    .o_y   (w_acc_signed)
  );

  assign w_res = w_acc_signed + r_op.addend_ext;

  // Control FSM, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_acc_hi <= '0;
      r_mpl    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_prod   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_op.mcand_mag  <= w_mcand_mag;
            r_op.neg        <= bus.sign & (bus.mcand[W-1] ^ bus.mplier[W-1]);
            r_op.addend_ext <= {{W{bus.sign & bus.addend[W-1]}}, bus.addend};
            r_acc_hi        <= '0;
            r_mpl           <= w_mpl_mag;
            r_cnt           <= '0;
            r_busy          <= 1'b1;
            r_state         <= RUN;
          end
        end
        RUN: begin
          r_acc_hi <= w_step[W:1];
          r_mpl    <= {w_step[0], r_mpl[W-1:1]};
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(W-1)) r_state <= FIX;
        end
        FIX: begin
          r_prod  <= w_res;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.prod = r_prod;

endmodule
